decode_stage_control: RTL and testbench

Decode-stage controller between instruction fetch and execute. Accepts fetched instructions over a valid/ready handshake and buffers them in a 2-entry in-order skid buffer. Classifies each instruction's format from its opcode and emits the sign-extended 32-bit immediate with the instruction and PC. Handles back-pressure, pipeline flush and (optionally) an illegal-opcode trap hold.

---
 rtl/decode_stage_control.sv | 162 ++++++++++++++++
 tb/tb_decode_stage_control.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_control.sv
// Decode-stage controller: 2-entry in-order skid buffer with opcode classification and immediate extraction.
// Optional illegal-opcode trap hold is enabled by defining DECODE_ILLEGAL_TRAP_EN.
module decode_stage_control #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instruction,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic [31:0] out_imm,
    output logic [2:0]  out_imm_type,
    output logic        out_illegal,
    output logic        trapped
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;
    localparam logic [1:0] ST_TRAP  = 2'd3;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  imm_type;
        logic        illegal;
    } entry_t;

    logic [1:0] state_q, state_d;
    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;
    entry_t     new_entry;
    logic       push, pop, trap_hit;

    // Classify at write time so the buffered entry already carries its immediate.
    always_comb begin
        logic [31:0] w;
        w                  = in_instruction;
        new_entry          = '0;
        new_entry.instr    = w;
        new_entry.pc       = in_pc;
        case (w[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
                new_entry.imm_type = IMM_I;
                new_entry.imm      = {{20{w[31]}}, w[31:20]};
            end
            7'b0100011: begin
                new_entry.imm_type = IMM_S;
                new_entry.imm      = {{20{w[31]}}, w[31:25], w[11:7]};
            end
            7'b1100011: begin
                new_entry.imm_type = IMM_B;
                new_entry.imm      = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                new_entry.imm_type = IMM_U;
                new_entry.imm      = {w[31:12], 12'b0};
            end
            7'b1101111: begin
                new_entry.imm_type = IMM_J;
                new_entry.imm      = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            end
            7'b0110011, 7'b0001111: begin
                new_entry.imm_type = IMM_NONE;
            end
            default: begin
                new_entry.illegal  = 1'b1;
            end
        endcase
    end

    assign in_ready  = (state_q == ST_EMPTY) || (state_q == ST_ONE);
    assign out_valid = (state_q == ST_ONE) || (state_q == ST_TWO);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign trap_hit  = pop && head_q.illegal;
    assign trapped   = (state_q == ST_TRAP);
`else
    assign trap_hit  = 1'b0;
    assign trapped   = 1'b0;
`endif

    // Head is always slot 0; a pop shifts the tail forward so FIFO order holds.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush || trap_hit) begin
            state_d = flush ? ST_EMPTY : ST_TRAP;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        head_d  = new_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            tail_d  = new_entry;
                            state_d = ST_TWO;
                        end
                        2'b01: begin
                            head_d  = '0;
                            state_d = ST_EMPTY;
                        end
                        2'b11: begin
                            head_d  = new_entry;
                        end
                        default: ;
                    endcase
                end
                ST_TWO: begin
                    if (pop) begin
                        head_d  = tail_q;
                        tail_d  = '0;
                        state_d = ST_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign out_instruction = out_valid ? head_q.instr    : '0;
    assign out_pc          = out_valid ? head_q.pc       : RESET_PC;
    assign out_imm         = out_valid ? head_q.imm      : '0;
    assign out_imm_type    = out_valid ? head_q.imm_type : IMM_NONE;
    assign out_illegal     = out_valid ? head_q.illegal  : 1'b0;

endmodule

// File: tb/tb_decode_stage_control.sv
// Self-checking bench for decode_stage_control: decode vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_decode_stage_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instruction;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [2:0]  out_imm_type;
    logic        out_illegal;
    logic        trapped;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    decode_stage_control #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
        .out_pc(out_pc), .out_imm(out_imm), .out_imm_type(out_imm_type),
        .out_illegal(out_illegal), .trapped(trapped)
    );

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } mentry_t;

    mentry_t     mq[$];
    bit          mtrap;
    logic [31:0] popped_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference decode computed arithmetically from the field weights of each format.
    function automatic void ref_decode(input logic [31:0] w, output logic [31:0] imm,
                                       output logic [2:0] typ, output logic ill);
        int v;
        v = 0; typ = 3'd0; ill = 1'b0;
        case (w[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: begin
                typ = 3'd1;
                v = int'(w[30:20]) - (w[31] ? 2048 : 0);
            end
            7'h23: begin
                typ = 3'd2;
                v = int'(w[30:25]) * 32 + int'(w[11:7]) - (w[31] ? 2048 : 0);
            end
            7'h63: begin
                typ = 3'd3;
                v = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2 - (w[31] ? 4096 : 0);
            end
            7'h37, 7'h17: begin
                typ = 3'd4;
                v = int'(w[31:12]) * 4096;
            end
            7'h6F: begin
                typ = 3'd5;
                v = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2
                    - (w[31] ? 1048576 : 0);
            end
            7'h33, 7'h0F: typ = 3'd0;
            default: ill = 1'b1;
        endcase
        imm = v;
    endfunction

    task automatic check_model();
        logic [31:0] imm;
        logic [2:0]  typ;
        logic        ill;
        bit          has = !mtrap && mq.size() > 0;
        chk("m_out_valid", {31'b0, out_valid}, {31'b0, has});
        chk("m_in_ready", {31'b0, in_ready}, {31'b0, (!mtrap && mq.size() < 2)});
        chk("m_trapped", {31'b0, trapped}, {31'b0, mtrap});
        if (has) begin
            ref_decode(mq[0].instr, imm, typ, ill);
            chk("m_instr", out_instruction, mq[0].instr);
            chk("m_pc", out_pc, mq[0].pc);
            chk("m_imm", out_imm, imm);
            chk("m_type", {29'b0, out_imm_type}, {29'b0, typ});
            chk("m_ill", {31'b0, out_illegal}, {31'b0, ill});
        end else begin
            chk("m_empty_bus", {out_instruction ^ out_imm, out_pc},
                {32'h0, 32'h0000_0000});
            chk("m_empty_flags", {29'b0, out_imm_type} | {31'b0, out_illegal}, 32'h0);
        end
    endtask

    // One clock: check outputs against model, drive inputs, advance model at the edge.
    task automatic cycle(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                         input bit ordy, input bit fl, output bit accepted);
        bit mpush, mpop, tr;
        mentry_t h, n;
        check_model();
        in_valid = iv; in_instruction = ins; in_pc = pc; out_ready = ordy; flush = fl;
        mpush = iv && !mtrap && mq.size() < 2;
        mpop  = ordy && !mtrap && mq.size() > 0;
        accepted = mpush && !fl;
        @(posedge clk);
        tr = 1'b0;
        if (fl) begin
            if (mpop) popped_log.push_back(mq[0].instr);
            mq.delete(); mtrap = 1'b0;
        end else begin
            if (mpop) begin
                logic [31:0] i2; logic [2:0] t2; logic il2;
                h = mq.pop_front();
                popped_log.push_back(h.instr);
                ref_decode(h.instr, i2, t2, il2);
                if (TRAP_EN && il2) begin
                    tr = 1'b1; mtrap = 1'b1; mq.delete();
                end
            end
            if (mpush && !tr) begin
                n.instr = ins; n.pc = pc;
                mq.push_back(n);
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input bit ordy, input bit fl);
        bit a;
        cycle(1'b0, 32'h0, 32'h0, ordy, fl, a);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic        ill;
    } vec_t;

    vec_t vecs[12];

    initial begin
        bit a;
        logic [31:0] opc_pool[12];
        logic [31:0] seq3[3];

        vecs[0]  = '{32'h0050_0093, 32'h0000_0005, 3'd1, 1'b0};
        vecs[1]  = '{32'hFE00_0EE3, 32'hFFFF_FFFC, 3'd3, 1'b0};
        vecs[2]  = '{32'h8000_00EF, 32'hFFF0_0000, 3'd5, 1'b0};
        vecs[3]  = '{32'h0011_2623, 32'h0000_000C, 3'd2, 1'b0};
        vecs[4]  = '{32'h1234_50B7, 32'h1234_5000, 3'd4, 1'b0};
        vecs[5]  = '{32'hFFFF_F097, 32'hFFFF_F000, 3'd4, 1'b0};
        vecs[6]  = '{32'h0020_81B3, 32'h0000_0000, 3'd0, 1'b0};
        vecs[7]  = '{32'h0FF0_000F, 32'h0000_0000, 3'd0, 1'b0};
        vecs[8]  = '{32'hFFC1_2083, 32'hFFFF_FFFC, 3'd1, 1'b0};
        vecs[9]  = '{32'h0000_007F, 32'h0000_0000, 3'd0, 1'b1};
        vecs[10] = '{32'h0000_0073, 32'h0000_0000, 3'd1, 1'b0};
        vecs[11] = '{32'h8000_00E7, 32'hFFFF_F800, 3'd1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_instruction = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0; mtrap = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'h0000_0000);
        chk("rst_trapped", {31'b0, trapped}, 32'd0);
        rst_n = 1'b1;

        // Latency: addi accepted at one edge is visible right after it.
        cycle(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0, a);
        chk("lat_valid", {31'b0, out_valid}, 32'd1);
        chk("lat_imm", out_imm, 32'h0000_0005);
        chk("lat_type", {29'b0, out_imm_type}, 32'd1);
        chk("lat_pc", out_pc, 32'h100);

        cycle(1'b1, 32'hFE00_0EE3, 32'h104, 1'b1, 1'b0, a);
        chk("beq_imm", out_imm, 32'hFFFF_FFFC);
        chk("beq_type", {29'b0, out_imm_type}, 32'd3);
        cycle(1'b1, 32'h8000_00EF, 32'h108, 1'b1, 1'b0, a);
        chk("jal_imm", out_imm, 32'hFFF0_0000);
        chk("jal_type", {29'b0, out_imm_type}, 32'd5);
        idle(1'b1, 1'b0);
        chk("drain_valid", {31'b0, out_valid}, 32'd0);

        // Decode table: push one, compare, flush it away.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, vecs[i].instr, 32'h200 + 32'(i) * 4, 1'b0, 1'b0, a);
            chk("tbl_instr", out_instruction, vecs[i].instr);
            chk("tbl_pc", out_pc, 32'h200 + 32'(i) * 4);
            chk("tbl_imm", out_imm, vecs[i].imm);
            chk("tbl_type", {29'b0, out_imm_type}, {29'b0, vecs[i].typ});
            chk("tbl_ill", {31'b0, out_illegal}, {31'b0, vecs[i].ill});
            idle(1'b0, 1'b1);
        end

        // Back-pressure: third push waits in TWO, then all drain in order.
        seq3[0] = 32'h0010_0093; seq3[1] = 32'h0020_0113; seq3[2] = 32'h0030_0193;
        popped_log.delete();
        cycle(1'b1, seq3[0], 32'h300, 1'b0, 1'b0, a);
        cycle(1'b1, seq3[1], 32'h304, 1'b0, 1'b0, a);
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_stable", out_instruction, seq3[0]);
        cycle(1'b1, seq3[2], 32'h308, 1'b0, 1'b0, a);
        chk("bp_hold", out_instruction, seq3[0]);
        begin
            bit done = 1'b0;
            for (int k = 0; k < 8 && !done; k++) begin
                cycle(1'b1, seq3[2], 32'h308, 1'b1, 1'b0, a);
                done = a;
            end
            chk("bp_accept", {31'b0, done}, 32'd1);
        end
        for (int k = 0; k < 4; k++) idle(1'b1, 1'b0);
        chk("bp_count", popped_log.size(), 32'd3);
        for (int k = 0; k < 3; k++)
            chk("bp_order", (k < popped_log.size()) ? popped_log[k] : 32'hDEAD_BEEF, seq3[k]);

        // Flush in state ONE with a simultaneous push: the push is lost.
        cycle(1'b1, 32'h0040_0213, 32'h400, 1'b0, 1'b0, a);
        cycle(1'b1, 32'h0050_0293, 32'h404, 1'b0, 1'b1, a);
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_ready", {31'b0, in_ready}, 32'd1);
        idle(1'b1, 1'b0);
        chk("fl_dropped", {31'b0, out_valid}, 32'd0);

        // Illegal entry followed by addi.
        cycle(1'b1, 32'h0000_007F, 32'h500, 1'b0, 1'b0, a);
        cycle(1'b1, 32'h0050_0093, 32'h504, 1'b0, 1'b0, a);
        chk("ill_flag", {31'b0, out_illegal}, 32'd1);
        chk("ill_imm", out_imm, 32'h0);
        idle(1'b1, 1'b0);
        if (TRAP_EN) begin
            chk("trap_set", {31'b0, trapped}, 32'd1);
            chk("trap_in_ready", {31'b0, in_ready}, 32'd0);
            chk("trap_valid", {31'b0, out_valid}, 32'd0);
            cycle(1'b1, 32'h0060_0313, 32'h508, 1'b1, 1'b0, a);
            chk("trap_hold", {31'b0, trapped}, 32'd1);
            idle(1'b0, 1'b1);
            chk("trap_clear", {31'b0, trapped}, 32'd0);
            chk("trap_ready", {31'b0, in_ready}, 32'd1);
        end else begin
            chk("noTrap_valid", {31'b0, out_valid}, 32'd1);
            chk("noTrap_next", out_instruction, 32'h0050_0093);
            chk("noTrap_trapped", {31'b0, trapped}, 32'd0);
            idle(1'b1, 1'b0);
        end

        // Asynchronous reset while holding two entries.
        cycle(1'b1, 32'h0070_0393, 32'h600, 1'b0, 1'b0, a);
        cycle(1'b1, 32'h0080_0413, 32'h604, 1'b0, 1'b0, a);
        chk("ar_pre_two", {31'b0, in_ready}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'b0, out_valid}, 32'd0);
        chk("ar_ready", {31'b0, in_ready}, 32'd1);
        chk("ar_pc", out_pc, 32'h0000_0000);
        mq.delete(); mtrap = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic against the queue model.
        opc_pool = '{32'h03, 32'h13, 32'h67, 32'h73, 32'h23, 32'h63,
                     32'h37, 32'h17, 32'h6F, 32'h33, 32'h0F, 32'h7F};
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] w;
            w = ($urandom() & 32'hFFFF_FF80) | opc_pool[$urandom_range(11, 0)];
            if ($urandom_range(15, 0) == 0) w = ($urandom() & 32'hFFFF_FF80) | 32'h00;
            cycle($urandom_range(3, 0) != 0, w, $urandom() & 32'hFFFF_FFFC,
                  $urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0, a);
        end
        check_model();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
